// File: rtl/pipe_scoreboard_pkg.sv
// rtl/pipe_scoreboard_pkg.sv - shared types and constants for the pipeline hazard scoreboard
// Purpose: pending-write entry type and the register-file forward code.
// Ports: none (package).
package pipe_scoreboard_pkg;

  // Storage width for a destination select; wide enough for any REGS up to 256.
  localparam int SB_WSEL_W = 8;

  // Forward-select code meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [SB_WSEL_W-1:0] wsel;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-producer priority encoder over the pending-write entries
// Purpose: find the lowest-index (newest) entry writing register rsel.
// Ports: entries (all tracked stages), rsel (register being read),
//        hit (some entry matches), idx (index of youngest match), is_load (that entry is a load).
module sb_match
  import pipe_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FBITS = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [SB_WSEL_W-1:0]  rsel,
  output logic                  hit,
  output logic [FBITS-1:0]      idx,
  output logic                  is_load
);

  // Scan from the oldest entry to the newest so the last assignment (lowest k) wins.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && (entries[k].wsel == rsel) && (rsel != '0)) begin
        hit     = 1'b1;
        idx     = FBITS'(k);
        is_load = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - register-hazard scoreboard: load-use stall and forward selects
// Purpose: track pending writes in EX..WB, stall decode on load-use, register forward selects.
// Ports: CLK, nRST (sync, active-high), advance, id_* (decode instruction fields), flush,
//        stall (comb), fwd_a / fwd_b (registered forward selects), stall_count (saturating).
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int REGS       = 32,
  parameter int RBITS      = $clog2(REGS),
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int FBITS      = $clog2(DEPTH + 1),
  parameter int CBITS      = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             advance,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wen,
  input  logic [RBITS-1:0] id_wsel,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [FBITS-1:0] fwd_a,
  output logic [FBITS-1:0] fwd_b,
  output logic [CBITS-1:0] stall_count
);

  sb_entry_t [DEPTH-1:0] entries;

  logic             hit_a, hit_b;
  logic             ld_a, ld_b;
  logic [FBITS-1:0] idx_a, idx_b;
  logic             haz_a, haz_b;
  logic [FBITS-1:0] nxt_a, nxt_b;
  sb_entry_t        new_entry;

  sb_match #(.DEPTH(DEPTH), .FBITS(FBITS)) u_match_a (
    .entries (entries),
    .rsel    (SB_WSEL_W'(id_rs)),
    .hit     (hit_a),
    .idx     (idx_a),
    .is_load (ld_a)
  );

  sb_match #(.DEPTH(DEPTH), .FBITS(FBITS)) u_match_b (
    .entries (entries),
    .rsel    (SB_WSEL_W'(id_rt)),
    .hit     (hit_b),
    .idx     (idx_b),
    .is_load (ld_b)
  );

  // A load producer at entry k can feed EX only once it has reached LOAD_AVAIL.
  assign haz_a = id_rs_used && hit_a && ld_a && ((int'(idx_a) + 1) < LOAD_AVAIL);
  assign haz_b = id_rt_used && hit_b && ld_b && ((int'(idx_b) + 1) < LOAD_AVAIL);
  assign stall = id_valid && !flush && (haz_a || haz_b);

  // After the next edge the producer sits one entry further down; the oldest
  // entry retires this cycle and is covered by register-file write-through.
  assign nxt_a = (id_rs_used && hit_a && (int'(idx_a) <= DEPTH - 2)) ? idx_a + FBITS'(1)
                                                                      : FBITS'(FWD_REGFILE);
  assign nxt_b = (id_rt_used && hit_b && (int'(idx_b) <= DEPTH - 2)) ? idx_b + FBITS'(1)
                                                                      : FBITS'(FWD_REGFILE);

  assign new_entry.valid   = id_valid && id_wen && !stall && !flush;
  assign new_entry.wsel    = SB_WSEL_W'(id_wsel);
  assign new_entry.is_load = id_is_load;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      entries     <= '0;
      fwd_a       <= FBITS'(FWD_REGFILE);
      fwd_b       <= FBITS'(FWD_REGFILE);
      stall_count <= '0;
    end else begin
      if (advance) begin
        for (int k = DEPTH - 1; k > 1; k--) begin
          entries[k] <= entries[k-1];
        end
        // A flushed EX instruction becomes a bubble instead of moving to MEM.
        entries[1] <= flush ? sb_entry_t'('0) : entries[0];
        entries[0] <= new_entry;
        fwd_a      <= (stall || flush || !id_valid) ? FBITS'(FWD_REGFILE) : nxt_a;
        fwd_b      <= (stall || flush || !id_valid) ? FBITS'(FWD_REGFILE) : nxt_b;
      end else if (flush) begin
        entries[0].valid <= 1'b0;
      end
      if (stall && advance && (stall_count != '1)) begin
        stall_count <= stall_count + CBITS'(1);
      end
    end
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the in-order MIPS pipeline. It replaces fixed per-stage hazard and forwarding comparisons with one tracker sized by the DEPTH and REGS parameters.
- It tracks pending register writes in a DEPTH-entry shift structure that mirrors the EX..WB latches.
- For the instruction in decode it decides two things:
  - stall on load-use;
  - registered forward selects, consumed by the execute-stage operand muxes.
- It also keeps a saturating stall counter for performance monitoring.

Parameters:
- REGS, 32: architectural register count; register 0 is never a hazard.
- RBITS, $clog2(REGS): register-select width.
- DEPTH, 3: tracked stages after decode (entry 0 = EX, DEPTH-1 = WB); minimum 2.
- LOAD_AVAIL, 2: entry index at which load data becomes forwardable; range 1..DEPTH-1.
- FBITS, $clog2(DEPTH+1): forward-select width.
- CBITS, 32: stall-counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  synchronous, active-high reset. Asserted = 1; sampled on the CLK edge.
- advance  in  1  pipeline latches enabled this cycle (ihit/dhit qualified).
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  RBITS  source-A register select.
- id_rt  in  RBITS  source-B register select.
- id_rs_used  in  1  source A is read.
- id_rt_used  in  1  source B is read.
- id_wen  in  1  instruction writes a register.
- id_wsel  in  RBITS  destination register.
- id_is_load  in  1  destination is written from dmemload.
- flush  in  1  branch/jump squash of the decode instruction and entry 0.
- stall  out  1  combinational load-use stall to PC/IFID enables.
- fwd_a  out  FBITS  registered; 0 = register file, k = forward from stage-entry k at EX time.
- fwd_b  out  FBITS  same as fwd_a, for source B.
- stall_count  out  CBITS  saturating count of stall cycles.

Behaviour:
- Entry state, per index k: valid, wsel, is_load.
- Reset (nRST=1 at the edge): all entries valid=0, wsel=0, is_load=0; fwd_a=fwd_b=0; stall_count=0. stall is therefore 0 in the cycle after reset.
- Match(k, r): entry[k].valid && entry[k].wsel==r && r!=0.
- Youngest match:
  - Search k from 0 upward; the lowest k with a match wins (newest producer).
  - Only the youngest match is evaluated; older matches are ignored.
- Load-use hazard (per used source): the youngest match k has is_load=1 and k+1 < LOAD_AVAIL.
- stall = id_valid && !flush && (hazard on A || hazard on B). Purely combinational; it does not depend on advance.
- Next forward select for a used source:
  - k+1 if the youngest match k <= DEPTH-2;
  - 0 if there is no match, the match is at k = DEPTH-1 (retires this cycle, covered by register-file write-through), or the source is unused.
- Update when advance=1:
  - entries shift: entry[k+1] <= entry[k]; entry[DEPTH-1] is discarded.
  - entry[0] <= {id_valid && id_wen && !stall && !flush, id_wsel, id_is_load}. A stall or flush inserts a bubble (valid=0).
  - fwd_a/fwd_b <= next selects; forced to 0 on stall, flush or !id_valid.
- advance=0: all entries and fwd_a/fwd_b hold.
- flush=1 with advance=1: entry[0] is cleared before the shift, so the squashed EX instruction never reaches MEM. The new entry[0] is a bubble. Older entries shift normally.
- flush=1 with advance=0: entry[0].valid is cleared immediately; everything else holds.
- stall_count increments on each edge where stall=1 and advance=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-stream overrides advance and flush.
- Simultaneous stall and flush: flush wins, so stall=0.

Decomposition:
- Shared package entries:
  - sb_entry_t struct {valid, wsel, is_load};
  - a constant for the register-file forward code (0).
- Sub-module sb_match: combinational youngest-match priority encoder. It is instantiated once per source and returns hit, index and is_load.

Test Plan:
1. Independent ops, with DEPTH=3 and LOAD_AVAIL=2: add $3 then add $4 reading $5 -> stall=0 throughout; fwd_a=fwd_b=0.
2. ALU-ALU dependency: add $3 issued, next instruction reads rs=$3 -> stall=0; one cycle later fwd_a=1. With one unrelated instruction in between -> fwd_a=2. With two in between -> fwd_a=0.
3. Load-use: lw $3 issued, next reads rt=$3 -> stall=1 for exactly one advancing cycle with a bubble at entry 0; then fwd_b=2; stall_count=1.
4. Hold vs flush:
   - lw $3 followed by a dependent instruction while advance=0 for 4 cycles -> stall stays 1 and entries hold; stall_count stays 0 until advance returns.
   - Separately, flush with entry0 = add $7 -> a following read of $7 gets fwd=0.
5. Register $0: lw $0 then a reader of $0 -> stall=0, fwd=0. Destination $31 with REGS=32 matches correctly.
6. Reset and saturation:
   - assert nRST during a stall -> next cycle stall=0, fwd_a=0, stall_count=0;
   - with CBITS=4, 20 stall cycles -> stall_count=15.
